// File: rtl/bist_pkg.sv
// Shared BIST definitions used by the pattern generator and the signature
// checker: default word width, the x^4+x+1 feedback taps and the
// controller state encoding.
package bist_pkg;

    localparam int         BIST_WIDTH = 4;
    // Taps of x^4+x+1 with the x^WIDTH term left implicit.
    localparam logic [3:0] BIST_POLY  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: one Galois-style shift per enabled
// cycle with the response word XORed in.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset, register returns to RST_VAL
//   load     - reload the register with seed (wins over shift_en)
//   seed     - value loaded when load=1
//   shift_en - perform one compaction step this cycle
//   din      - response word folded in on a compaction step
//   sig      - current register contents
module misr_core #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] POLY    = 4'b0011,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (shift_en) begin
            // Multiply by x modulo the polynomial, then fold in the response.
            sig_d = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? POLY : '0)
                  ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_signature_checker.sv
// BIST response compactor and pass/fail checker. Compacts CYCLES enabled
// response words into a MISR, then compares the result with the golden
// signature captured when the run was started.
// Handshake: start is a single-cycle request, accepted only in IDLE or DONE;
// busy is high while a run is in progress (RUN, CHECK); done stays high in
// DONE until the next accepted start, and pass is meaningful only while
// done=1 (it reads 0 otherwise).
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   start         - begin a run (reloads SEED, clears count, latches golden)
//   enable        - sample qualifier for din while running
//   din           - response word from the circuit under test
//   golden        - expected signature, captured on accepted start
//   busy, done    - run status
//   pass          - signature matched golden (valid while done=1)
//   signature     - current MISR contents
//   state_dbg     - controller state, for observation only
module misr_signature_checker
    import bist_pkg::*;
#(
    parameter int               WIDTH  = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = BIST_POLY,
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter int               CYCLES = 16,
    parameter int               CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] sig;

    misr_core #(
        .WIDTH   (WIDTH),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (SEED),
        .shift_en (shift_en),
        .din      (din),
        .sig      (sig)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // enable in the same cycle as start is deliberately ignored:
                // the first sample is taken one cycle after acceptance.
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    golden_d = golden;
                    pass_d   = 1'b0;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (enable) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // Count parks at CYCLES-1; no wrap within a run.
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                pass_d  = (sig == golden_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig;
    assign state_dbg = state_q;

endmodule
